// File: rtl/chacha_pkg.sv
// Shared ChaCha20 block-layout types and constants.
package chacha_pkg;

  typedef logic [31:0] word_t;

  localparam int BLOCK_BYTES     = 64;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int BYTES_PER_WORD  = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_t;

endpackage

// File: rtl/block_packer.sv
// Byte-stream to 4x4 word matrix packer (ChaCha20 block layout).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FILL  | accepting bytes; each byte lands at the next little-endian lane
//   HOLD  | block complete or flushed; presented until out_ready
//
// Byte i lands in word i>>2, lane i[1:0]; word w sits at outdata[w>>2][w&3].
// The matrix is cleared on release, so a partial block's unfilled bytes read
// as zero without any masking on the output side.
module block_packer
  import chacha_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ROWS      = 4,
  parameter int COLS      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_SIZE-1:0]              in_byte,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output word_t [ROWS-1:0][COLS-1:0]        outdata,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [6:0]                        out_count,
  output logic                              out_last
);

  localparam logic [6:0] COUNT_FULL = 7'(BLOCK_BYTES);

  packer_state_t             r_state;
  logic [6:0]                r_count;
  logic                      r_last;
  word_t [ROWS-1:0][COLS-1:0] r_mat;

  logic [6:0] w_count_nxt;
  logic [1:0] w_row;
  logic [1:0] w_col;
  logic [4:0] w_lsb;
  logic       w_close;

  // Decode the write position of the next byte from the running count.
  always_comb begin
    w_count_nxt = r_count + 7'd1;
    w_row       = r_count[5:4];
    w_col       = r_count[3:2];
    w_lsb       = {r_count[1:0], 3'b000};
    w_close     = (w_count_nxt == COUNT_FULL) || in_last;
  end

  // Fill/hold sequencing, byte-lane writes and the release clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_count <= '0;
      r_last  <= 1'b0;
      r_mat   <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (in_valid) begin
            r_mat[w_row][w_col][w_lsb +: 8] <= in_byte[7:0];
            r_count <= w_count_nxt;
            if (w_close) begin
              r_state <= HOLD;
              r_last  <= in_last;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state <= FILL;
            r_count <= '0;
            r_last  <= 1'b0;
            r_mat   <= '0;
          end
        end
      endcase
    end
  end

  // Outputs come straight from state registers; no input reaches them combinationally.
  always_comb begin
    in_ready  = (r_state == FILL);
    out_valid = (r_state == HOLD);
    outdata   = r_mat;
    out_count = r_count;
    out_last  = r_last;
  end

endmodule

// File: doc/block_packer.md
Name: block_packer

Overview:
- Byte-to-matrix packer: the inverse of the matrix serialiser/concatenator path.
- Accepts a byte stream over a valid/ready handshake and assembles it little-endian into a 4x4 matrix of 32-bit words. That matrix is the ChaCha20 block state/keystream layout.
- Presents each completed or flushed block on a valid/ready output, together with a byte count and a last flag.
- Feeds the keystream-XOR and Poly1305 block stages from a byte-oriented source.

Parameters:
- DATA_SIZE, 8, width of one input beat in bits; only 8 is supported.
- ROWS, 4, matrix rows.
- COLS, 4, matrix columns; BLOCK_BYTES = ROWS*COLS*4 = 64.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_byte  input  DATA_SIZE  stream byte.
- in_valid  input  1  in_byte is valid.
- in_last  input  1  qualifies the final byte of a message; only meaningful with in_valid.
- in_ready  output  1  packer can accept a byte this cycle.
- outdata  output  word_t [ROWS-1:0][COLS-1:0]  assembled block.
- out_valid  output  1  outdata/out_count/out_last are valid.
- out_ready  input  1  downstream consumes the block.
- out_count  output  7  number of real bytes in the block, 1..64.
- out_last  output  1  block was closed by in_last.

Behaviour:
- Byte acceptance: a byte is accepted on an edge where in_valid && in_ready.
- Byte placement:
  - Accepted byte index i (0..63) goes to word w = i>>2, lane i[1:0].
  - Word w is outdata[w>>2][w&3].
  - Lane L is bits [8L+7:8L], so byte 0 is the LSB of outdata[0][0].
- FSM, two states:
  - FILL: in_ready=1, out_valid=0. On accept, write the byte and increment the byte count.
    - Accept with count becoming 64 → HOLD, out_last = in_last.
    - Accept with in_last=1 and count < 64 → HOLD, out_last = 1.
  - HOLD: in_ready=0, out_valid=1. outdata, out_count and out_last are held stable until out_ready.
    - On out_valid && out_ready: clear the whole matrix to zero, count=0, out_last=0, go to FILL.
- Latency: out_valid rises on the cycle after the edge that accepted the closing byte.
- Throughput: at most one block per 65 cycles (64 fills + 1 HOLD handshake). No byte is accepted in the HOLD release cycle, since in_ready=0 combinationally in HOLD.
- Padding: unfilled bytes of a partial block read as zero. This is guaranteed by the clear on release and by reset.
- out_count is the internal count, held in HOLD. A full block reports 64 (7 bits).
- in_last on the 64th byte: single block, out_count=64, out_last=1. No extra empty block is emitted.
- in_last with in_valid=0 is ignored. An empty message cannot be signalled, and no zero-byte block is ever produced.
- in_valid may drop at any time in FILL. The partial state is kept indefinitely with no timeout.
- out_ready asserted while out_valid=0 has no effect.
- Reset, any state, including mid-fill or mid-HOLD, next edge:
  - State = FILL, count=0, matrix all zero, out_last=0.
  - out_valid=0, in_ready=1 (combinational from state).
  - Partial data is discarded.
- Reset values of outputs: in_ready=1, out_valid=0, out_count=0, out_last=0, outdata=all zero.
- No combinational path from in_* to out_*. in_ready depends only on state.

Decomposition:
- Shared package chacha_pkg:
  - typedef word_t = logic [31:0].
  - Constants BLOCK_BYTES=64, WORDS_PER_BLOCK=16, BYTES_PER_WORD=4.
  - Enum packer_state_t {FILL, HOLD}.
- Single module: no sub-module is warranted. The byte-lane write is a decoded indexed assignment, and the FSM has two states.

Test Plan:
- Full block: bytes 0x00..0x3F back-to-back, in_last=0, out_ready=1 → one cycle after byte 0x3F:
  - out_valid=1, outdata[0][0]=32'h03020100, outdata[1][2]=32'h1B1A1918, outdata[3][3]=32'h3F3E3D3C.
  - out_count=64, out_last=0, released the next cycle.
- Partial flush: AA BB CC DD EE, in_last on EE → outdata[0][0]=32'hDDCCBBAA, outdata[0][1]=32'h000000EE, all other words 0, out_count=5, out_last=1.
- Backpressure: complete a block, hold out_ready=0 for 10 cycles while in_valid=1 → in_ready=0 throughout, outputs bit-stable, no byte lost. The first byte after release lands at index 0 with the previous data cleared.
- Gapped input and two blocks: 128 bytes with random in_valid gaps → two blocks, each with out_count=64, contents matching the reference little-endian packing; the second block shows no residue of the first.
- in_last on the 64th byte → exactly one block, out_count=64, out_last=1; the next in_valid byte starts a fresh block.
- Mid-operation reset: assert rst after 20 bytes, then send 3 bytes 01 02 03 with in_last → outdata[0][0]=32'h00030201, out_count=3. Also assert rst during HOLD → out_valid=0 on the next cycle.
